axi4_r_responder: RTL and testbench
===================================

// Module: axi4_r_responder
// PURPOSE
//  AXI4 read-channel slave (AR in, R out): the responder end of the AXI4_R_IF that the
//  completion-data path masters. Accepts one INCR burst at a time, reads a 1-cycle-latency
//  synchronous SRAM port beat by beat, and returns beats with RID/RRESP/RLAST.
//  Tolerates arbitrary RREADY backpressure without losing or duplicating beats.
// PARAMETERS
//  DATA_WIDTH  PCIE_PKG::PIPE_DATA_WIDTH  R data width in bits; beat size = DATA_WIDTH/8 bytes
//  ADDR_WIDTH  32                         AXI byte-address width
//  ID_WIDTH    4                          ARID/RID width
//  MEM_AW      10                         SRAM word-address width (MEM_DEPTH = 2**MEM_AW words)
//  FIFO_DEPTH  4                          output beat buffer depth (power of 2, >= 3)
// PORTS
//  clk         in   1           clock
//  rst         in   1           async reset, active-high
//  arvalid     in   1           AR request valid
//  arready     out  1           AR accept
//  arid        in   ID_WIDTH    request ID
//  araddr      in   ADDR_WIDTH  start byte address (beat-aligned)
//  arlen       in   8           beats - 1
//  arburst     in   2           burst type; only INCR (2'b01) is serviced as data
//  mem_rden    out  1           SRAM read enable
//  mem_addr    out  MEM_AW      SRAM word address
//  mem_rdata   in   DATA_WIDTH  SRAM data, valid the cycle after mem_rden
//  rvalid      out  1           R beat valid
//  rready      in   1           R beat accept
//  rdata       out  DATA_WIDTH  beat data
//  rid         out  ID_WIDTH    = latched arid
//  rresp       out  2           2'b00 OKAY, 2'b10 SLVERR
//  rlast       out  1           final beat of burst
// BEHAVIOUR
//  - Reset (async, rst=1): arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0,
//    mem_rden=0, mem_addr=0; FSM -> IDLE; FIFO and counters emptied. Reset mid-burst
//    abandons the burst; no beat is emitted after reset release until a new AR handshake.
//  - FSM: IDLE -> (arvalid&&arready) -> ISSUE -> (last read issued) -> DRAIN
//    -> (last beat accepted: rvalid&&rready&&rlast) -> IDLE.
//  - arready = 1 only in IDLE (registered, asserted the cycle after entering IDLE).
//    Single outstanding burst; no AR accepted during ISSUE/DRAIN.
//  - On AR handshake latch arid, arlen, arburst; word address = araddr[MEM_AW+LSB-1:LSB],
//    LSB = $clog2(DATA_WIDTH/8). Beat counter 9 bits, total beats = arlen+1 (1..256).
//  - ISSUE: mem_rden=1 when credit = in_flight + fifo_count < FIFO_DEPTH; mem_addr
//    increments by 1 per issued read and wraps modulo MEM_DEPTH.
//  - mem_rdata captured into FIFO the cycle after mem_rden, tagged with rlast (beat ==
//    arlen) and rresp. rvalid/rdata/rlast/rresp driven from FIFO head (registered FIFO).
//  - Latency: AR handshake at cycle T -> first mem_rden at T+1 -> first rvalid at T+3.
//    With rready held 1, one beat per cycle thereafter (no bubbles).
//  - rresp = SLVERR for every beat if arburst != INCR, or for a beat whose byte address
//    exceeds MEM_DEPTH*beat bytes (address bits above MEM_AW+LSB nonzero); such beats
//    carry rdata=0 and perform no SRAM read, but still occupy a FIFO slot and beat count.
//  - AXI rules: once rvalid=1, rdata/rid/rresp/rlast hold until rvalid&&rready.
//    rvalid never depends combinationally on rready.
//  - FIFO full: no read issued (credit check guarantees no overflow). Empty: rvalid=0.
//    Simultaneous push and pop: count unchanged, order preserved.
// STRUCTURE
//  - PCIE_PKG: AXI_RESP_OKAY/AXI_RESP_SLVERR, AXI_BURST_INCR constants, rd_state_t enum.
//  - Sub-module r_beat_fifo (FIFO_DEPTH x {rdata,rresp,rlast}, registered outputs,
//    full/empty/count). Top holds FSM, address/beat counters, credit logic.
// TESTING
//  1. arlen=0, araddr=0x40, rready=1 -> one beat at T+3, rlast=1, rresp=OKAY, rdata=mem[2].
//  2. arlen=7, rready=1 -> 8 back-to-back beats mem[a..a+7], rlast only on 8th, arready back in IDLE.
//  3. arlen=15, rready random 30% -> 16 beats in order, no loss/dup, outputs stable while stalled.
//  4. arburst=2'b00, arlen=3 -> 4 beats rresp=SLVERR, rdata=0, mem_rden never asserted.
//  5. start at last SRAM word, arlen=1 with in-range addr width limited -> 2nd beat SLVERR, no wrap read.
//  6. rst pulsed after beat 3 of arlen=7 -> all outputs 0 asynchronously; new AR arlen=0 completes normally.

Source files
------------

// File: rtl/axi4_r_responder_pkg.sv
// Shared constants and types for the AXI4 read-channel responder.
package axi4_r_responder_pkg;

    localparam int unsigned PIPE_DATA_WIDTH = 256;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } rd_state_t;

endpackage

// File: rtl/axi4_r_responder_if.sv
// AXI4 read address and read data channels between a read master and the responder.
interface axi4_r_responder_if
    import axi4_r_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) ();
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ID_WIDTH-1:0]   rid;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arburst, rready,
        input  arready, rvalid, rdata, rid, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arburst, rready,
        output arready, rvalid, rdata, rid, rresp, rlast
    );
endinterface

// File: rtl/axi4_r_responder_r_beat_fifo.sv
// Small beat buffer {rdata, rresp, rlast}; head entry is read straight from flops.
module axi4_r_responder_r_beat_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign count_o = count_q;

endmodule

// File: rtl/axi4_r_responder.sv
// AXI4 read responder: one INCR burst at a time from a 1-cycle-latency SRAM, with
// credit-based issue so the beat FIFO never overflows under RREADY backpressure.
module axi4_r_responder
    import axi4_r_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4_r_responder_if.slave     bus,
    output logic                  mem_rden,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int unsigned Lsb   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned WordW = ADDR_WIDTH - Lsb;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FifoW = DATA_WIDTH + 3;

    rd_state_t           state_q, state_d;
    logic                arready_q, arready_d;
    logic [ID_WIDTH-1:0] rid_q;
    logic [7:0]          arlen_q;
    logic                burst_err_q;
    logic [WordW-1:0]    word_q;
    logic [8:0]          beat_q;
    // Read-pipeline stage: the beat whose SRAM data arrives this cycle.
    logic                p_valid_q, p_err_q, p_last_q;

    logic                ar_hs, issue, pop, beat_err, beat_last, credit_ok;
    logic                fifo_empty, fifo_full;
    logic [CntW-1:0]     fifo_count;
    logic [FifoW-1:0]    push_data, head;
    logic [DATA_WIDTH-1:0] push_rdata;

    assign ar_hs     = bus.arvalid && arready_q;
    assign pop       = bus.rvalid && bus.rready;
    assign beat_last = (beat_q == {1'b0, arlen_q});
    // Beats past the end of the SRAM error out rather than wrap.
    assign beat_err  = burst_err_q || (|word_q[WordW-1:MEM_AW]);
    assign credit_ok = (fifo_count + CntW'(p_valid_q)) < CntW'(FIFO_DEPTH);
    assign mem_addr  = word_q[MEM_AW-1:0];

    always_comb begin
        state_d   = state_q;
        arready_d = 1'b0;
        issue     = 1'b0;
        mem_rden  = 1'b0;
        unique case (state_q)
            StIdle: begin
                arready_d = !ar_hs;
                if (ar_hs) state_d = StIssue;
            end
            StIssue: begin
                issue    = credit_ok && !fifo_full;
                mem_rden = issue && !beat_err;
                if (issue && beat_last) state_d = StDrain;
            end
            StDrain: begin
                if (pop && bus.rlast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            arready_q   <= 1'b0;
            rid_q       <= '0;
            arlen_q     <= '0;
            burst_err_q <= 1'b0;
            word_q      <= '0;
            beat_q      <= '0;
            p_valid_q   <= 1'b0;
            p_err_q     <= 1'b0;
            p_last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            p_valid_q <= issue;
            p_err_q   <= beat_err;
            p_last_q  <= beat_last;
            if (ar_hs) begin
                rid_q       <= bus.arid;
                arlen_q     <= bus.arlen;
                burst_err_q <= (bus.arburst != AXI_BURST_INCR);
                word_q      <= bus.araddr[ADDR_WIDTH-1:Lsb];
                beat_q      <= '0;
            end else if (issue) begin
                word_q <= word_q + 1'b1;
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    assign push_rdata = p_err_q ? '0 : mem_rdata;
    assign push_data  = {push_rdata, (p_err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY), p_last_q};

    axi4_r_responder_r_beat_fifo #(
        .Width (FifoW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (p_valid_q),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign bus.arready = arready_q;
    assign bus.rvalid  = !fifo_empty;
    assign bus.rdata   = head[FifoW-1:3];
    assign bus.rresp   = head[2:1];
    assign bus.rlast   = head[0];
    assign bus.rid     = rid_q;

endmodule

// File: tb/tb_axi4_r_responder.sv
// Scoreboard bench for axi4_r_responder: AR driver pushes expected beats, R monitor checks.
module tb_axi4_r_responder;
    localparam int unsigned DW    = 256;
    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 4;
    localparam int unsigned MAW   = 10;
    localparam int unsigned FD    = 4;
    localparam int unsigned BYTES = DW / 8;
    localparam int unsigned DEPTH = 1 << MAW;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic [IW-1:0] id;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mem_rden;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_rdata = '0;
    logic [DW-1:0]  sram [DEPTH];

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    rden_cnt = 0;
    int    rd_base = 0;
    int    hs_cyc = 0;
    int    rr_mode = 0;
    beat_t sb [$];

    axi4_r_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    axi4_r_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .MEM_AW     (MAW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_rden  (mem_rden),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rden) mem_rdata <= sram[mem_addr];
        if (!rst && mem_rden) rden_cnt <= rden_cnt + 1;
    end

    task automatic check(input bit ok, input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // R monitor: compares every accepted beat against the scoreboard head.
    logic          prev_v = 1'b0, prev_r = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic [1:0]    prev_resp = '0;
    logic [IW-1:0] prev_id = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r)
                check(bus.rvalid && bus.rdata == prev_d && bus.rresp == prev_resp &&
                      bus.rlast == prev_last && bus.rid == prev_id,
                      "r_hold_while_stalled", bus.rdata, prev_d);
            if (bus.rvalid && bus.rready) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_beat", bus.rdata, '0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check(bus.rdata == e.data, "rdata", bus.rdata, e.data);
                    check(bus.rresp == e.resp, "rresp", DW'(bus.rresp), DW'(e.resp));
                    check(bus.rlast == e.last, "rlast", DW'(bus.rlast), DW'(e.last));
                    check(bus.rid == e.id, "rid", DW'(bus.rid), DW'(e.id));
                end
            end
            prev_v = bus.rvalid;
            prev_r = bus.rready;
            prev_d = bus.rdata;
            prev_resp = bus.rresp;
            prev_last = bus.rlast;
            prev_id = bus.rid;
        end
    end

    initial begin
        bus.rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 0) bus.rready = 1'b1;
            else bus.rready = ($urandom_range(0, 99) >= 30);
        end
    end

    // Reference model: beat i lives at araddr + i*BYTES; outside SRAM or non-INCR -> SLVERR.
    task automatic issue_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            output int exp_reads);
        bit ok;
        exp_reads = 0;
        for (int i = 0; i <= int'(len); i++) begin
            beat_t e;
            longint unsigned b;
            bit err;
            b = longint'(addr) + longint'(i) * BYTES;
            err = (burst != 2'b01) || (b >= longint'(DEPTH) * BYTES);
            e.data = err ? '0 : sram[int'(b / BYTES)];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            e.id = id;
            if (!err) exp_reads++;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.arvalid = 1'b1;
        bus.arid = id;
        bus.araddr = addr;
        bus.arlen = len;
        bus.arburst = burst;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.arready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check(1'b0, "ar_handshake_timeout", '0, 1);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        hs_cyc = cyc;
        rd_base = rden_cnt;
    endtask

    task automatic wait_done(input string name, input int exp_reads);
        bit idle;
        for (int k = 0; k < 3000 && sb.size() != 0; k++) @(negedge clk);
        check(sb.size() == 0, {name, "_all_beats"}, DW'(sb.size()), '0);
        idle = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.arready) begin
                idle = 1'b1;
                break;
            end
        end
        check(idle, {name, "_arready_idle"}, DW'(idle), 1);
        check(rden_cnt - rd_base == exp_reads, {name, "_sram_reads"},
              DW'(rden_cnt - rd_base), DW'(exp_reads));
    endtask

    task automatic check_reset_outputs(input string name);
        check(!bus.arready && !bus.rvalid && !bus.rlast && bus.rresp == 2'b00 &&
              bus.rid == '0 && !mem_rden && mem_addr == '0,
              {name, "_ctrl_zero"},
              DW'({bus.arready, bus.rvalid, bus.rlast, bus.rresp, bus.rid, mem_rden, mem_addr}),
              '0);
        check(bus.rdata == '0, {name, "_rdata_zero"}, bus.rdata, '0);
    endtask

    initial begin
        int n;
        int first_gap;
        bit seen;
        bus.arvalid = 1'b0;
        bus.arid = '0;
        bus.araddr = '0;
        bus.arlen = '0;
        bus.arburst = 2'b01;
        for (int i = 0; i < int'(DEPTH); i++)
            for (int w = 0; w < int'(DW / 32); w++) sram[i][w*32 +: 32] = $urandom;

        #2;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // 1: single beat, latency and first read timing.
        rr_mode = 0;
        issue_ar(4'h3, 32'h40, 8'd0, 2'b01, n);
        check(mem_rden && mem_addr == 10'd2, "t1_first_read", DW'({mem_rden, mem_addr}),
              DW'({1'b1, 10'd2}));
        first_gap = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rvalid) begin
                first_gap = cyc - hs_cyc;
                break;
            end
        end
        check(first_gap == 2, "t1_latency", DW'(first_gap), 2);
        wait_done("t1", n);

        // 2: 8 beats back to back with rready held high.
        issue_ar(4'h5, 32'h100, 8'd7, 2'b01, n);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rvalid) break;
        end
        seen = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (!bus.rvalid) seen = 1'b0;
        end
        check(seen, "t2_no_bubbles", DW'(seen), 1);
        wait_done("t2", n);

        // 3: 16 beats under random backpressure.
        rr_mode = 1;
        issue_ar(4'h9, 32'h800, 8'd15, 2'b01, n);
        wait_done("t3", n);

        // 4: non-INCR burst -> all SLVERR, no SRAM access.
        issue_ar(4'h2, 32'h200, 8'd3, 2'b00, n);
        wait_done("t4", n);

        // 5: last SRAM word; second beat falls off the end.
        issue_ar(4'h7, 32'((DEPTH - 1) * BYTES), 8'd1, 2'b01, n);
        wait_done("t5", n);

        // Random bursts, some near the top of the SRAM, some non-INCR.
        for (int r = 0; r < 12; r++) begin
            logic [IW-1:0] id;
            logic [7:0] len;
            logic [1:0] burst;
            int word;
            id = IW'($urandom_range(0, 15));
            len = 8'($urandom_range(0, 15));
            burst = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b01;
            word = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 4, DEPTH - 1)
                                               : $urandom_range(0, DEPTH - 1);
            rr_mode = $urandom_range(0, 1);
            issue_ar(id, 32'(word * BYTES), len, burst, n);
            wait_done("rand", n);
        end

        // 6: reset mid-burst after three beats.
        rr_mode = 0;
        issue_ar(4'hB, 32'h1000, 8'd7, 2'b01, n);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rvalid) break;
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_outputs("t6_async");
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rvalid) seen = 1'b1;
        end
        check(!seen, "t6_no_beat_after_reset", DW'(seen), 0);
        issue_ar(4'h4, 32'h60, 8'd0, 2'b01, n);
        wait_done("t6_new", n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
